exe_mem_req_unit: RTL and testbench
===================================

Name: exe_mem_req_unit

Overview:
- Parametrised data-memory request unit for the execute stage. It replaces the single-outstanding stop logic with an in-flight FIFO of up to DEPTH requests.
- Generates byte enables and aligned write data for SW/SB/SH/SWL/SWR, and detects address-alignment faults.
- Issues requests on the addr_ok/data_ok SRAM-like interface and returns ordered, registered responses to the writeback stage, with flush support for exceptions.

Parameters:
DEPTH, 4, maximum outstanding accepted-but-unanswered requests (power of two, 2..16)
RDEST_W, 5, width of destination-register tag carried per request
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  execute stage holds a memory instruction this cycle
req_is_store  in  1  1=store, 0=load
req_type  in  3  load: LW0 LB1 LBU2 LH3 LHU4 LWL5 LWR6; store: SW0 SB1 SH2 SWL3 SWR4
req_addr  in  32  effective address (ALU result)
req_wdata  in  32  rt value for stores
req_rdest  in  RDEST_W  load destination register
req_kill  in  1  exception/interrupt on this instruction; suppress issue
flush  in  1  discard all in-flight responses and current request
data_req  out  1  request valid to data RAM
data_wr  out  1  write request
data_wen  out  4  byte enables (0000 for loads)
data_addr  out  32  request address, word-aligned for SWL/LWL, byte address otherwise
data_wdata  out  32  lane-aligned store data
data_addr_ok  in  1  RAM accepts request this cycle
data_data_ok  in  1  RAM returns one response this cycle (in order)
data_rdata  in  32  read data
stop  out  1  stall execute stage
fault  out  1  alignment fault on current request
fault_code  out  5  0x04 AdEL, 0x05 AdES, 0 otherwise
rsp_valid  out  1  registered response valid (one cycle)
rsp_is_store  out  1  response belongs to a store
rsp_rdest  out  RDEST_W  tag of response
rsp_type  out  3  req_type of response
rsp_off  out  2  req_addr[1:0] of response
rsp_rdata  out  32  captured data_rdata
busy  out  1  count != 0
spurious_ok  out  1  sticky: data_data_ok seen with count==0

Behaviour:
- Reset (async, resetn=0): count=0, FIFO pointers=0, all drop flags=0; rsp_valid, rsp_* and spurious_ok are 0.
- fault (combinational):
  - LW/SW when addr[1:0]!=0.
  - LH/LHU/SH when addr[0]!=0.
  - Gated by req_valid. fault_code=0x05 if store else 0x04.
- issue = req_valid & ~fault & ~req_kill & ~flush. data_req = issue & (count<DEPTH).
- stop = issue & (count==DEPTH | ~data_addr_ok). A fault, kill or flush never stalls.
- data_wen / data_wdata for stores (a=addr[1:0]):
  - SW: 1111, wdata unchanged.
  - SB: 0001<<a, wdata<<8a.
  - SH: 0011<<a (a in {0,2}), wdata<<8a.
  - SWL: a=0..3 -> 0001/0011/0111/1111, wdata>>(8*(3-a)).
  - SWR: 1111<<a, wdata<<8a.
  - Loads: wen=0000, wdata=0.
- Push on data_req & data_addr_ok: store {is_store, rdest, type, off, drop=0} at tail; count+1.
- Pop on data_data_ok & count!=0:
  - Head retires and count-1.
  - Next cycle, rsp_valid = ~head.drop, with rsp_* from the head entry and rsp_rdata=data_rdata.
  - rsp_valid is otherwise 0; rsp_* hold their last values.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- data_data_ok with count==0 (including in the cycle of the first push): ignored and sets spurious_ok, which stays set until reset.
- Flush:
  - Sets drop=1 on every entry valid at that edge.
  - Suppresses data_req that cycle.
  - A pop in the flush cycle is itself dropped.
  - Dropped entries still consume their data_data_ok. Count is not cleared, so the RAM stays in sync.
- Pointer wrap is modulo DEPTH. count never exceeds DEPTH and never underflows.
- resetn asserted mid-transaction clears all state immediately. The bench must not drive data_data_ok for pre-reset requests.

Test Plan:
- LW addr 0x1000, addr_ok same cycle, data_ok 2 cycles later with rdata 0xDEADBEEF -> data_req=1, wen=0000, stop=0; rsp_valid one cycle after data_ok, rsp_rdata=0xDEADBEEF, rsp_rdest=req_rdest, count back to 0.
- SB addr 0x2003 wdata 0x000000AB; SWL addr 0x2001 wdata 0x11223344; SWR addr 0x2002 wdata 0x11223344 -> wen=1000, wdata=0xAB000000; wen=0011, wdata=0x00001122; wen=1100, wdata=0x33440000.
- DEPTH=4: 5 back-to-back loads with addr_ok=1 and no data_ok -> 4 pushes; 5th cycle data_req=0, stop=1, count=4. One data_ok -> stop drops the next cycle and the 5th request issues.
- LH addr 0x3001 and SW addr 0x3002 -> fault=1, codes 0x04 / 0x05, data_req=0, stop=0; req_kill=1 on a valid LW -> data_req=0.
- 3 outstanding loads, flush=1, then 3 data_ok pulses -> rsp_valid stays 0, count returns to 0. A 4th data_ok -> spurious_ok=1.
- addr_ok push and data_ok pop in the same cycle with count=2 -> count stays 2, responses in order. resetn low mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/exe_mem_req_unit_if.sv
// SRAM-like data-memory bus: request on addr_ok handshake, in-order
// responses on data_ok.
interface exe_mem_req_unit_if;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_wen, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_wen, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/exe_mem_req_unit.sv
// Execute-stage data-memory request unit: alignment checks, store lane
// steering, and an in-flight FIFO of up to DEPTH outstanding requests
// whose responses are returned in order, registered, to writeback.
module exe_mem_req_unit #(
    parameter int DEPTH   = 4,
    parameter int RDEST_W = 5,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    input  logic               req_is_store,
    input  logic [2:0]         req_type,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [RDEST_W-1:0] req_rdest,
    input  logic               req_kill,
    input  logic               flush,
    exe_mem_req_unit_if.master mem,
    output logic               stop,
    output logic               fault,
    output logic [4:0]         fault_code,
    output logic               rsp_valid,
    output logic               rsp_is_store,
    output logic [RDEST_W-1:0] rsp_rdest,
    output logic [2:0]         rsp_type,
    output logic [1:0]         rsp_off,
    output logic [31:0]        rsp_rdata,
    output logic               busy,
    output logic               spurious_ok
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic               is_store;
        logic [RDEST_W-1:0] rdest;
        logic [2:0]         rtype;
        logic [1:0]         off;
        logic               drop;
    } entry_t;

    entry_t           fifo [DEPTH];
    entry_t           hd;
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;
    logic             full, issue, push, pop;
    logic [1:0]       a;
    logic             word_aligned;

    assign a     = req_addr[1:0];
    assign hd    = fifo[head];
    assign full  = (count == CNT_W'(DEPTH));
    assign busy  = (count != '0);
    assign issue = req_valid & ~fault & ~req_kill & ~flush;
    assign push  = mem.data_req & mem.data_addr_ok;
    assign pop   = mem.data_data_ok & busy;

    // Alignment fault: word ops need a[1:0]==0, halfword ops need a[0]==0.
    always_comb begin
        fault = 1'b0;
        if (req_valid) begin
            if (req_is_store) begin
                case (req_type)
                    3'd0:    fault = |a;
                    3'd2:    fault = a[0];
                    default: fault = 1'b0;
                endcase
            end else begin
                case (req_type)
                    3'd0:       fault = |a;
                    3'd3, 3'd4: fault = a[0];
                    default:    fault = 1'b0;
                endcase
            end
        end
    end

    assign fault_code = fault ? (req_is_store ? 5'h05 : 5'h04) : 5'h00;

    // A fault, kill or flush never stalls; only a full FIFO or a RAM refusal does.
    assign mem.data_req = issue & ~full;
    assign stop         = issue & (full | ~mem.data_addr_ok);
    assign mem.data_wr  = req_is_store;

    // SWL/LWL fetch the whole containing word; everything else keeps the byte address.
    assign word_aligned  = req_is_store ? (req_type == 3'd3) : (req_type == 3'd5);
    assign mem.data_addr = word_aligned ? {req_addr[31:2], 2'b00} : req_addr;

    // Store lane steering; SWL right-shifts the high bytes of rt into the low lanes.
    always_comb begin
        mem.data_wen   = 4'b0000;
        mem.data_wdata = 32'h0;
        if (req_is_store) begin
            case (req_type)
                3'd0: begin
                    mem.data_wen   = 4'b1111;
                    mem.data_wdata = req_wdata;
                end
                3'd1: begin
                    mem.data_wen   = 4'b0001 << a;
                    mem.data_wdata = req_wdata << {a, 3'b000};
                end
                3'd2: begin
                    mem.data_wen   = 4'b0011 << a;
                    mem.data_wdata = req_wdata << {a, 3'b000};
                end
                3'd3: begin
                    mem.data_wen   = 4'b1111 >> (~a);
                    mem.data_wdata = req_wdata >> {~a, 3'b000};
                end
                3'd4: begin
                    mem.data_wen   = 4'b1111 << a;
                    mem.data_wdata = req_wdata << {a, 3'b000};
                end
                default: ;
            endcase
        end
    end

    // In-flight FIFO; flush marks every slot dropped so responses still drain in sync.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else begin
            if (flush)
                for (int i = 0; i < DEPTH; i++) fifo[i].drop <= 1'b1;
            if (push) begin
                fifo[tail] <= '{is_store: req_is_store, rdest: req_rdest,
                                rtype: req_type, off: a, drop: 1'b0};
                tail <= tail + PTR_W'(1);
            end
            if (pop) head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Registered response; fields hold when nothing retires.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid    <= 1'b0;
            rsp_is_store <= 1'b0;
            rsp_rdest    <= '0;
            rsp_type     <= '0;
            rsp_off      <= '0;
            rsp_rdata    <= '0;
        end else begin
            rsp_valid <= pop & ~hd.drop & ~flush;
            if (pop) begin
                rsp_is_store <= hd.is_store;
                rsp_rdest    <= hd.rdest;
                rsp_type     <= hd.rtype;
                rsp_off      <= hd.off;
                rsp_rdata    <= mem.data_rdata;
            end
        end
    end

    // Sticky flag for a response with nothing outstanding.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) spurious_ok <= 1'b0;
        else if (mem.data_data_ok & ~busy) spurious_ok <= 1'b1;
    end
endmodule

// File: tb/tb_exe_mem_req_unit.sv
// Scoreboard bench for exe_mem_req_unit: accepted requests are queued,
// retired by data_ok and compared with the registered response.
module tb_exe_mem_req_unit;
    localparam int DEPTH = 4;
    localparam int RW    = 5;

    typedef struct {
        logic          is_store;
        logic [RW-1:0] rdest;
        logic [2:0]    ty;
        logic [1:0]    off;
        logic          drop;
        logic [31:0]   rdata;
    } exp_t;

    logic          clk, resetn;
    logic          req_valid, req_is_store, req_kill, flush;
    logic [2:0]    req_type;
    logic [31:0]   req_addr, req_wdata;
    logic [RW-1:0] req_rdest;
    logic          stop, fault, rsp_valid, rsp_is_store, busy, spurious_ok;
    logic [4:0]    fault_code;
    logic [RW-1:0] rsp_rdest;
    logic [2:0]    rsp_type;
    logic [1:0]    rsp_off;
    logic [31:0]   rsp_rdata;

    exe_mem_req_unit_if bus();

    exe_mem_req_unit #(.DEPTH(DEPTH), .RDEST_W(RW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_is_store(req_is_store), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rdest(req_rdest),
        .req_kill(req_kill), .flush(flush), .mem(bus.master),
        .stop(stop), .fault(fault), .fault_code(fault_code),
        .rsp_valid(rsp_valid), .rsp_is_store(rsp_is_store), .rsp_rdest(rsp_rdest),
        .rsp_type(rsp_type), .rsp_off(rsp_off), .rsp_rdata(rsp_rdata),
        .busy(busy), .spurious_ok(spurious_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t sb[$];
    bit   mspur = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic bit mdl_fault(input logic st, input logic [2:0] ty, input logic [1:0] a);
        logic [1:0] need;
        need = 2'b00;
        if (st) begin
            if (ty == 3'd0) need = 2'b11;
            if (ty == 3'd2) need = 2'b01;
        end else begin
            if (ty == 3'd0) need = 2'b11;
            if (ty == 3'd3 || ty == 3'd4) need = 2'b01;
        end
        return (a & need) != 2'b00;
    endfunction

    // Byte-lane view: lane i takes source byte src of rt, or is left untouched.
    function automatic void mdl_store(input logic st, input logic [2:0] ty, input logic [1:0] a,
                                      input logic [31:0] wd, output logic [3:0] w,
                                      output logic [31:0] d);
        int ai;
        int src;
        ai = int'(a);
        w  = 4'b0000;
        d  = 32'h0;
        if (st) begin
            for (int i = 0; i < 4; i++) begin
                src = -1;
                case (ty)
                    3'd0: src = i;
                    3'd1: if (i == ai) src = 0;
                    3'd2: if (i == ai || i == ai + 1) src = i - ai;
                    3'd3: if (i <= ai) src = i + 3 - ai;
                    3'd4: if (i >= ai) src = i - ai;
                    default: ;
                endcase
                if (src >= 0) begin
                    w[i] = 1'b1;
                    d[8*i +: 8] = wd[8*src +: 8];
                end
            end
        end
    endfunction

    task automatic set_req(input logic st, input logic [2:0] ty, input logic [31:0] ad,
                           input logic [31:0] wd, input logic [RW-1:0] rd);
        req_valid = 1'b1; req_is_store = st; req_type = ty;
        req_addr = ad; req_wdata = wd; req_rdest = rd;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_kill = 1'b0; flush = 1'b0;
        bus.data_data_ok = 1'b0;
    endtask

    task automatic dok(input logic [31:0] rd);
        bus.data_data_ok = 1'b1; bus.data_rdata = rd;
    endtask

    // One clock: check comb outputs, advance the model at the edge, check the response.
    task automatic step(input bit cc);
        bit          f, iss, psh, pp, ev;
        exp_t        e, n;
        logic [3:0]  w;
        logic [31:0] d, ea;
        #1;
        f   = req_valid && mdl_fault(req_is_store, req_type, req_addr[1:0]);
        iss = req_valid && !f && !req_kill && !flush;
        psh = iss && (sb.size() < DEPTH) && bus.data_addr_ok;
        pp  = bus.data_data_ok && (sb.size() != 0);
        if (cc) begin
            chk("fault", fault, f);
            chk("fault_code", fault_code, f ? (req_is_store ? 32'h5 : 32'h4) : 32'h0);
            chk("data_req", bus.data_req, iss && (sb.size() < DEPTH));
            chk("stop", stop, iss && ((sb.size() == DEPTH) || !bus.data_addr_ok));
            if (req_valid) begin
                mdl_store(req_is_store, req_type, req_addr[1:0], req_wdata, w, d);
                ea = ((req_is_store && req_type == 3'd3) || (!req_is_store && req_type == 3'd5))
                     ? {req_addr[31:2], 2'b00} : req_addr;
                chk("data_wen", bus.data_wen, w);
                chk("data_wdata", bus.data_wdata, d);
                chk("data_addr", bus.data_addr, ea);
                chk("data_wr", bus.data_wr, req_is_store);
            end
        end
        ev = 1'b0;
        @(posedge clk);
        if (pp) begin
            e = sb.pop_front();
            ev = !(e.drop || flush);
            e.rdata = bus.data_rdata;
        end
        if (flush) foreach (sb[i]) sb[i].drop = 1'b1;
        if (psh) begin
            n.is_store = req_is_store; n.rdest = req_rdest; n.ty = req_type;
            n.off = req_addr[1:0]; n.drop = 1'b0; n.rdata = 32'h0;
            sb.push_back(n);
        end
        if (bus.data_data_ok && !pp) mspur = 1'b1;
        @(negedge clk);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
            chk("rsp_rdest", rsp_rdest, e.rdest);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_type", rsp_type, e.ty);
            chk("rsp_off", rsp_off, e.off);
            chk("rsp_is_store", rsp_is_store, e.is_store);
        end
        chk("busy", busy, sb.size() != 0);
        chk("spurious_ok", spurious_ok, mspur);
    endtask

    initial begin
        resetn = 1'b0;
        req_is_store = 1'b0; req_type = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        req_rdest = '0; idle();
        bus.data_addr_ok = 1'b1; bus.data_rdata = 32'h0;
        #3;
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_spurious", spurious_ok, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_rdest", rsp_rdest, 32'h0);
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // single LW, response two cycles after acceptance
        set_req(1'b0, 3'd0, 32'h1000, 32'h0, 5'd7);
        step(1'b1);
        idle(); step(1'b1);
        dok(32'hDEADBEEF); step(1'b1);
        idle(); step(1'b1);

        // store lane steering
        set_req(1'b1, 3'd1, 32'h2003, 32'h000000AB, 5'd1);
        #1; chk("sb_wen", bus.data_wen, 4'b1000); chk("sb_wdata", bus.data_wdata, 32'hAB000000);
        step(1'b1);
        set_req(1'b1, 3'd3, 32'h2001, 32'h11223344, 5'd2);
        #1; chk("swl_wen", bus.data_wen, 4'b0011); chk("swl_wdata", bus.data_wdata, 32'h00001122);
        step(1'b1);
        set_req(1'b1, 3'd4, 32'h2002, 32'h11223344, 5'd3);
        #1; chk("swr_wen", bus.data_wen, 4'b1100); chk("swr_wdata", bus.data_wdata, 32'h33440000);
        step(1'b1);
        set_req(1'b1, 3'd2, 32'h2006, 32'hCAFE5678, 5'd4);
        step(1'b1);
        idle();
        for (int i = 0; i < 4; i++) begin dok(32'h100 + i); step(1'b1); end
        idle(); step(1'b1);

        // fill to DEPTH, fifth request stalls until one response retires
        for (int i = 0; i < 5; i++) begin
            set_req(1'b0, 3'(i % 5), 32'h4000 + 32'(i * 4), 32'h0, 5'(i + 10));
            if (i == 4) begin #1; chk("full_stop", stop, 1'b1); chk("full_req", bus.data_req, 1'b0); end
            step(1'b1);
        end
        dok(32'hA0A0A0A0); step(1'b1);
        bus.data_data_ok = 1'b0;
        #1; chk("refill_stop", stop, 1'b0);
        step(1'b1);
        idle();
        for (int i = 0; i < 4; i++) begin dok(32'hB000 + i); step(1'b1); end
        idle(); step(1'b1);

        // addr_ok low stalls
        set_req(1'b0, 3'd1, 32'h5001, 32'h0, 5'd9);
        bus.data_addr_ok = 1'b0; step(1'b1);
        bus.data_addr_ok = 1'b1; step(1'b1);
        idle(); dok(32'h5555AAAA); step(1'b1);
        idle();

        // faults and kill
        set_req(1'b0, 3'd3, 32'h3001, 32'h0, 5'd1);
        #1; chk("lh_fault", fault, 1'b1); chk("lh_code", fault_code, 5'h04);
        step(1'b1);
        set_req(1'b1, 3'd0, 32'h3002, 32'h12345678, 5'd1);
        #1; chk("sw_fault", fault, 1'b1); chk("sw_code", fault_code, 5'h05);
        step(1'b1);
        set_req(1'b0, 3'd0, 32'h3004, 32'h0, 5'd2);
        req_kill = 1'b1;
        #1; chk("kill_req", bus.data_req, 1'b0);
        step(1'b1);
        idle(); step(1'b1);

        // flush with three in flight; pop in the flush cycle is dropped too
        for (int i = 0; i < 3; i++) begin set_req(1'b0, 3'd0, 32'h6000 + 32'(i * 4), 32'h0, 5'(i + 20)); step(1'b1); end
        idle();
        set_req(1'b0, 3'd0, 32'h6100, 32'h0, 5'd30);
        flush = 1'b1; dok(32'hF0F0F0F0);
        #1; chk("flush_req", bus.data_req, 1'b0);
        step(1'b1);
        idle();
        for (int i = 0; i < 2; i++) begin dok(32'hF100 + i); step(1'b1); end
        dok(32'hF200); step(1'b1);
        idle(); step(1'b1);

        // simultaneous push and pop at count 2
        for (int i = 0; i < 2; i++) begin set_req(1'b0, 3'd4, 32'h7000 + 32'(i * 2), 32'h0, 5'(i + 1)); step(1'b1); end
        set_req(1'b0, 3'd2, 32'h7007, 32'h0, 5'd3);
        dok(32'h77770000); step(1'b1);
        idle();
        for (int i = 0; i < 3; i++) begin dok(32'h7100 + i); step(1'b1); end
        idle(); step(1'b1);

        // asynchronous reset mid-stream
        for (int i = 0; i < 2; i++) begin set_req(1'b0, 3'd0, 32'h8000 + 32'(i * 4), 32'h0, 5'(i + 5)); step(1'b1); end
        idle(); dok(32'h88888888); step(1'b1);
        idle();
        #2 resetn = 1'b0;
        #1;
        chk("arst_rsp_valid", rsp_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_spurious", spurious_ok, 1'b0);
        chk("arst_rsp_rdata", rsp_rdata, 32'h0);
        chk("arst_rsp_rdest", rsp_rdest, 32'h0);
        chk("arst_data_req", bus.data_req, 1'b0);
        sb.delete(); mspur = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        set_req(1'b0, 3'd0, 32'h9000, 32'h0, 5'd11); step(1'b1);
        idle(); dok(32'h90909090); step(1'b1);
        idle(); step(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
